// File: rtl/msg_to_pkt_ser.sv
// msg_to_pkt_ser
// Captures one Wishbone bus message through a valid/ready handshake and
// serialises it into a packet of flits (HEAD, ADDR, SEL, DATA beats) on a
// valid/ready flit interface toward the router-side injection queue.
// Reads carry only HEAD and ADDR. Messages with an illegal burst length are
// accepted, dropped and reported with a one-cycle err_o pulse.
// All outputs are decoded from registered state only.

module msg_to_pkt_ser #(
    parameter int BUS_DATA_WIDTH    = 32,
    parameter int BUS_ADDRESS_WIDTH = 32,
    parameter int BUS_SEL_WIDTH     = 4,
    parameter int MAX_BURST_LENGTH  = 8,
    parameter int FLIT_WIDTH        = 32,
    parameter int LEN_WIDTH         = 4
) (
    input  logic                                         CLK_I,
    input  logic                                         RST_I,
    input  logic                                         msg_valid_i,
    output logic                                         msg_ready_o,
    input  logic [MAX_BURST_LENGTH*BUS_DATA_WIDTH-1:0]   data_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]                 address_i,
    input  logic [MAX_BURST_LENGTH*BUS_SEL_WIDTH-1:0]    sel_i,
    input  logic                                         WE_I,
    input  logic                                         reply_for_wb_master_interface_i,
    input  logic [LEN_WIDTH-1:0]                         burst_len_i,
    output logic [FLIT_WIDTH-1:0]                        flit_o,
    output logic                                         flit_valid_o,
    output logic                                         flit_head_o,
    output logic                                         flit_tail_o,
    input  logic                                         flit_ready_i,
    output logic                                         err_o,
    output logic                                         busy_o
);

    // Beat index only needs to address MAX_BURST_LENGTH beats.
    localparam int BEAT_W = (MAX_BURST_LENGTH > 1) ? $clog2(MAX_BURST_LENGTH) : 1;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST_LENGTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [BEAT_W-1:0]    BEAT_ONE = BEAT_W'(1);

    // Packet FSM encoding.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HEAD = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_SEL  = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;

    // ------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------
    logic [2:0]                                       state_q, state_d;
    logic [BEAT_W-1:0]                                beat_q,  beat_d;
    logic [LEN_WIDTH-1:0]                             len_q,   len_d;
    logic                                             reply_q, reply_d;
    logic                                             we_q,    we_d;
    logic [BUS_ADDRESS_WIDTH-1:0]                     addr_q,  addr_d;
    logic [MAX_BURST_LENGTH*BUS_SEL_WIDTH-1:0]        sel_q,   sel_d;
    logic [MAX_BURST_LENGTH-1:0][BUS_DATA_WIDTH-1:0]  data_q,  data_d;
    logic                                             err_q,   err_d;

    // Handshake and decode helpers.
    logic capture;
    logic len_legal;
    logic flit_fire;
    logic last_beat;

    assign capture   = msg_valid_i && (state_q == S_IDLE);
    assign len_legal = (burst_len_i != '0) && (burst_len_i <= MAX_LEN);
    assign flit_fire = (state_q != S_IDLE) && flit_ready_i;
    assign last_beat = (LEN_WIDTH'(beat_q) == (len_q - LEN_ONE));

    // Next-state logic: message capture, packet sequencing and beat counting.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        beat_d  = beat_q;
        len_d   = len_q;
        reply_d = reply_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    // Register the whole message so later input changes
                    // cannot disturb the packet being serialised.
                    len_d   = burst_len_i;
                    reply_d = reply_for_wb_master_interface_i;
                    we_d    = WE_I;
                    addr_d  = address_i;
                    sel_d   = sel_i;
                    data_d  = data_i;
                    beat_d  = '0;
                    if (len_legal) begin
                        state_d = S_HEAD;
                    end else begin
                        // Malformed length: drop the message, stay idle.
                        err_d = 1'b1;
                    end
                end
            end

            S_HEAD: begin
                if (flit_fire) begin
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                if (flit_fire) begin
                    // Reads end on the address flit.
                    state_d = we_q ? S_SEL : S_IDLE;
                end
            end

            S_SEL: begin
                if (flit_fire) begin
                    state_d = S_DATA;
                    beat_d  = '0;
                end
            end

            S_DATA: begin
                if (flit_fire) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State update with synchronous active-high reset.
    always_ff @(posedge CLK_I) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST_I) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            len_q   <= '0;
            reply_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            reply_q <= reply_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Flit payload selected from registered state; zero whenever no flit is valid.
    always_comb begin
        flit_o = '0;
        case (state_q)
            S_HEAD: begin
                flit_o[LEN_WIDTH-1:0] = len_q;
                flit_o[LEN_WIDTH]     = reply_q;
                flit_o[LEN_WIDTH+1]   = we_q;
            end
            S_ADDR:  flit_o = FLIT_WIDTH'(addr_q);
            S_SEL:   flit_o = FLIT_WIDTH'(sel_q);
            S_DATA:  flit_o = FLIT_WIDTH'(data_q[beat_q]);
            default: flit_o = '0;
        endcase
    end

    // Status and framing flags decoded from registered state.
    always_comb begin
        msg_ready_o  = (state_q == S_IDLE);
        flit_valid_o = (state_q != S_IDLE);
        busy_o       = (state_q != S_IDLE);
        flit_head_o  = (state_q == S_HEAD);
        flit_tail_o  = ((state_q == S_ADDR) && !we_q) ||
                       ((state_q == S_DATA) && last_beat);
        err_o        = err_q;
    end

endmodule

// File: tb/tb_msg_to_pkt_ser.sv
// Directed self-checking bench for msg_to_pkt_ser: reset, read and write
// packets, flow-control stalls, illegal lengths, mid-packet reset and
// back-to-back messages. Outputs are sampled and inputs driven on the
// falling clock edge.

module tb_msg_to_pkt_ser;

    logic         clk;
    logic         rst;
    logic         msg_valid;
    logic         msg_ready;
    logic [255:0] data;
    logic [31:0]  address;
    logic [31:0]  sel;
    logic         we;
    logic         reply;
    logic [3:0]   burst_len;
    logic [31:0]  flit;
    logic         flit_valid;
    logic         flit_head;
    logic         flit_tail;
    logic         flit_ready;
    logic         err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] wexp [6];

    msg_to_pkt_ser dut (
        .CLK_I                           (clk),
        .RST_I                           (rst),
        .msg_valid_i                     (msg_valid),
        .msg_ready_o                     (msg_ready),
        .data_i                          (data),
        .address_i                       (address),
        .sel_i                           (sel),
        .WE_I                            (we),
        .reply_for_wb_master_interface_i (reply),
        .burst_len_i                     (burst_len),
        .flit_o                          (flit),
        .flit_valid_o                    (flit_valid),
        .flit_head_o                     (flit_head),
        .flit_tail_o                     (flit_tail),
        .flit_ready_i                    (flit_ready),
        .err_o                           (err),
        .busy_o                          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("%s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_flit(input string tag, input logic [31:0] f, input logic h, input logic t);
        check({tag, " valid"}, {31'd0, flit_valid}, 32'd1);
        check({tag, " flit"},  flit, f);
        check({tag, " head"},  {31'd0, flit_head}, {31'd0, h});
        check({tag, " tail"},  {31'd0, flit_tail}, {31'd0, t});
        check({tag, " busy"},  {31'd0, busy}, 32'd1);
        check({tag, " ready"}, {31'd0, msg_ready}, 32'd0);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " valid"}, {31'd0, flit_valid}, 32'd0);
        check({tag, " flit"},  flit, 32'd0);
        check({tag, " head"},  {31'd0, flit_head}, 32'd0);
        check({tag, " tail"},  {31'd0, flit_tail}, 32'd0);
        check({tag, " busy"},  {31'd0, busy}, 32'd0);
        check({tag, " ready"}, {31'd0, msg_ready}, 32'd1);
    endtask

    task automatic scramble_inputs();
        msg_valid = 1'b0;
        data      = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
        address   = $urandom;
        sel       = $urandom;
        we        = 1'($urandom);
        reply     = 1'($urandom);
        burst_len = 4'($urandom);
    endtask

    // Presents a read message at the current falling edge and checks the packet.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic rep,
                           input logic [3:0] len, input logic [31:0] exp_head);
        msg_valid = 1'b1;
        address   = addr;
        we        = 1'b0;
        reply     = rep;
        burst_len = len;
        data      = '1;
        sel       = '1;
        @(negedge clk);
        scramble_inputs();
        expect_flit({tag, " head"}, exp_head, 1'b1, 1'b0);
        @(negedge clk);
        expect_flit({tag, " addr"}, addr, 1'b0, 1'b1);
        @(negedge clk);
        expect_idle({tag, " end"});
    endtask

    // Standard write (len 3) with optional stalls and optional reset on beat 1.
    task automatic run_write(input string tag, input int stall_sel, input int stall_b1,
                             input bit reset_b1);
        msg_valid = 1'b1;
        address   = 32'h40;
        we        = 1'b1;
        reply     = 1'b0;
        burst_len = 4'd3;
        sel       = 32'h0FF;
        data      = '0;
        data[0 +: 32]  = 32'hA0;
        data[32 +: 32] = 32'hA1;
        data[64 +: 32] = 32'hA2;
        for (int i = 0; i < 6; i++) begin
            int stall;
            @(negedge clk);
            if (i == 0) scramble_inputs();
            expect_flit($sformatf("%s f%0d", tag, i), wexp[i], i == 0, i == 5);
            if (reset_b1 && i == 4) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                expect_idle({tag, " after rst"});
                return;
            end
            stall = (i == 2) ? stall_sel : ((i == 4) ? stall_b1 : 0);
            if (stall > 0) begin
                flit_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    expect_flit($sformatf("%s f%0d stall%0d", tag, i, s), wexp[i], i == 0, i == 5);
                end
                flit_ready = 1'b1;
            end
        end
        @(negedge clk);
        expect_idle({tag, " end"});
    endtask

    // Illegal length: err pulse for exactly one cycle, no flits, ready stays high.
    task automatic do_illegal(input string tag, input logic [3:0] len, input logic w);
        msg_valid = 1'b1;
        burst_len = len;
        we        = w;
        reply     = 1'b1;
        address   = 32'h55;
        @(negedge clk);
        msg_valid = 1'b0;
        check({tag, " err pulse"}, {31'd0, err}, 32'd1);
        expect_idle({tag, " cyc1"});
        @(negedge clk);
        check({tag, " err clear"}, {31'd0, err}, 32'd0);
        expect_idle({tag, " cyc2"});
    endtask

    initial begin
        wexp = '{32'h23, 32'h40, 32'hFF, 32'hA0, 32'hA1, 32'hA2};

        rst        = 1'b1;
        msg_valid  = 1'b0;
        data       = '0;
        address    = '0;
        sel        = '0;
        we         = 1'b0;
        reply      = 1'b0;
        burst_len  = '0;
        flit_ready = 1'b1;

        repeat (2) @(negedge clk);
        expect_idle("reset");
        check("reset err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // Read, len 1, reply 1 -> head 0x11 then address with tail.
        do_read("read1", 32'h0000_1234, 1'b1, 4'd1, 32'h0000_0011);

        // Write len 3, full-rate then with stalls on SEL and beat 1.
        run_write("write", 0, 0, 1'b0);
        run_write("wstall", 3, 2, 1'b0);

        // Illegal lengths, write and read.
        do_illegal("len0", 4'd0, 1'b1);
        do_illegal("len9", 4'd9, 1'b0);

        // Reset in the middle of DATA beat 1, then a clean read.
        run_write("wrst", 0, 0, 1'b1);
        do_read("read2", 32'hDEAD_BEEF, 1'b0, 4'd2, 32'h0000_0002);

        // Back-to-back reads with msg_valid held high.
        msg_valid = 1'b1;
        address   = 32'h100;
        we        = 1'b0;
        reply     = 1'b1;
        burst_len = 4'd1;
        @(negedge clk);
        expect_flit("b2b A head", 32'h11, 1'b1, 1'b0);
        @(negedge clk);
        expect_flit("b2b A addr", 32'h100, 1'b0, 1'b1);
        address   = 32'h200;
        reply     = 1'b0;
        @(negedge clk);
        expect_idle("b2b bubble");
        @(negedge clk);
        expect_flit("b2b B head", 32'h01, 1'b1, 1'b0);
        @(negedge clk);
        msg_valid = 1'b0;
        expect_flit("b2b B addr", 32'h200, 1'b0, 1'b1);
        @(negedge clk);
        expect_idle("b2b end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
